// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for up to four masters with grant-wait and hold-time
// watchdogs; all outputs are registered.
module bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned GRANT_WAIT  = 4,
  parameter int unsigned MAX_HOLD    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   bus_util,
  input  logic                   slave_busy,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [1:0]             grant_id,
  output logic                   arb_busy,
  output logic                   timeout
);

  localparam int unsigned WAIT_W = $clog2(GRANT_WAIT) + 1;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(GRANT_WAIT);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  localparam logic [1:0]        LAST_ID  = 2'(NUM_MASTERS - 1);
  localparam logic [2:0]        NM       = 3'(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY,
    RELEASE
  } state_t;

  state_t                 state, state_next;
  logic [WAIT_W-1:0]      wait_cnt, wait_next, wait_inc;
  logic [HOLD_W-1:0]      hold_cnt, hold_next, hold_inc;
  logic [1:0]             ptr, ptr_next;
  logic [3:0]             req_pad;
  logic                   owner_req;
  logic                   sel_found;
  logic [1:0]             sel_id;
  logic [NUM_MASTERS-1:0] grant_next;
  logic [1:0]             grant_id_next;
  logic                   timeout_next;

  // Pad requests to four bits so any 2-bit index is in range.
  always_comb begin
    req_pad                  = '0;
    req_pad[NUM_MASTERS-1:0] = req;
  end

  assign owner_req = req_pad[grant_id];
  assign wait_inc  = (wait_cnt == WAIT_LIM) ? wait_cnt : wait_cnt + 1'b1;
  assign hold_inc  = (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + 1'b1;

  // Circular search for the first requester at or after ptr.
  always_comb begin : pick
    logic [2:0] idx;
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= NM) idx = idx - NM;
      if (!sel_found && req_pad[idx[1:0]]) begin
        sel_found = 1'b1;
        sel_id    = idx[1:0];
      end
    end
  end

  // The timeout pulse fires on the edge a counter reaches its limit; the
  // tenure is revoked on the following edge, so an in-cycle normal end wins.
  always_comb begin
    state_next    = state;
    wait_next     = wait_cnt;
    hold_next     = hold_cnt;
    ptr_next      = ptr;
    grant_next    = grant;
    grant_id_next = grant_id;
    timeout_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_found) begin
          state_next    = GRANT;
          grant_next    = NUM_MASTERS'(1) << sel_id;
          grant_id_next = sel_id;
          wait_next     = '0;
        end
      end
      GRANT: begin
        if (wait_cnt == WAIT_LIM) begin
          state_next = RELEASE;
          grant_next = '0;
        end else if (bus_util) begin
          state_next = BUSY;
          wait_next  = '0;
          hold_next  = '0;
        end else if (!owner_req) begin
          state_next = RELEASE;
          grant_next = '0;
        end else begin
          wait_next = wait_inc;
          if (wait_inc == WAIT_LIM) timeout_next = 1'b1;
        end
      end
      BUSY: begin
        if (hold_cnt == HOLD_LIM) begin
          state_next = RELEASE;
          grant_next = '0;
        end else if (!bus_util && !slave_busy) begin
          state_next = RELEASE;
          grant_next = '0;
        end else begin
          hold_next = hold_inc;
          if (hold_inc == HOLD_LIM) timeout_next = 1'b1;
        end
      end
      RELEASE: begin
        state_next = IDLE;
        wait_next  = '0;
        hold_next  = '0;
        ptr_next   = (grant_id == LAST_ID) ? 2'd0 : grant_id + 2'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      hold_cnt <= '0;
      ptr      <= '0;
      grant    <= '0;
      grant_id <= '0;
      arb_busy <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      hold_cnt <= hold_next;
      ptr      <= ptr_next;
      grant    <= grant_next;
      grant_id <= grant_id_next;
      arb_busy <= (state_next != IDLE);
      timeout  <= timeout_next;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: each driven cycle queues the outputs
// expected after the next rising edge; a negedge monitor pops and compares.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = '0;
  logic       bus_util = 1'b0;
  logic       slave_busy = 1'b0;
  logic [2:0] grant;
  logic [1:0] grant_id;
  logic       arb_busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct packed {
    int         due;
    logic [2:0] g;
    logic [1:0] id;
    logic       busy;
    logic       to;
    logic       chk_id;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  cur;
  string cur_tag;
  logic [6:0] got_w, exp_w;

  bus_arbiter #(.NUM_MASTERS(3), .GRANT_WAIT(4), .MAX_HOLD(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bus_util  (bus_util),
    .slave_busy(slave_busy),
    .grant     (grant),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // grant_id is only meaningful while a grant is held, or right after reset.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      cur     = exp_q.pop_front();
      cur_tag = tag_q.pop_front();
      got_w   = {grant, cur.chk_id ? grant_id : 2'b00, arb_busy, timeout};
      exp_w   = {cur.g, cur.chk_id ? cur.id : 2'b00, cur.busy, cur.to};
      check(cur_tag, 32'(got_w), 32'(exp_w));
    end
  end

  task automatic step(input logic r, input logic [2:0] rq, input logic bu, input logic sb,
                      input logic [2:0] eg, input logic [1:0] eid, input logic eb,
                      input logic et, input string tag);
    exp_t e;
    @(negedge clk);
    rst        = r;
    req        = rq;
    bus_util   = bu;
    slave_busy = sb;
    e.due    = cyc + 1;
    e.g      = eg;
    e.id     = eid;
    e.busy   = eb;
    e.to     = et;
    e.chk_id = r || (eg != 3'b000);
    exp_q.push_back(e);
    tag_q.push_back($sformatf("%s@%0d", tag, cyc + 1));
  endtask

  task automatic s(input logic [2:0] rq, input logic bu, input logic sb,
                   input logic [2:0] eg, input logic [1:0] eid, input logic eb,
                   input logic et, input string tag);
    step(1'b0, rq, bu, sb, eg, eid, eb, et, tag);
  endtask

  // Grant, two cycles of bus_util, release, one idle cycle.
  task automatic tenure(input logic [2:0] rq, input logic [2:0] eg, input logic [1:0] eid);
    s(rq, 1'b0, 1'b0, eg, eid, 1'b1, 1'b0, "rr_grant");
    repeat (2) s(rq, 1'b1, 1'b0, eg, eid, 1'b1, 1'b0, "rr_busy");
    s(rq, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "rr_release");
    s(rq, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "rr_gap");
  endtask

  initial begin
    step(1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "reset");
    step(1'b1, 3'b111, 1'b1, 1'b1, 3'b000, 2'd0, 1'b0, 1'b0, "reset_hold");
    s(3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "idle");

    // Single request from master 1; ptr ends at 2.
    s(3'b010, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, "single_grant");
    repeat (3) s(3'b010, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, "single_busy");
    s(3'b010, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "single_release");
    s(3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "single_idle");

    // ptr=2 with only masters 0/1 requesting wraps to 0; owner drops req early.
    s(3'b011, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0, "wrap_grant");
    s(3'b010, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "drop_release");
    s(3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "drop_idle");

    // Grant-wait timeout: pulse 4 cycles after grant, revoke next cycle.
    s(3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0, "gto_grant");
    repeat (3) s(3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0, "gto_wait");
    s(3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b1, "gto_pulse");
    s(3'b001, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "gto_release");
    s(3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "gto_idle");

    // ptr=1: req 101 picks master 2; then reset in the middle of BUSY.
    s(3'b101, 1'b0, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0, "rst_grant");
    repeat (2) s(3'b101, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0, "rst_busy");
    step(1'b1, 3'b101, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "mid_reset");

    // Post-reset ptr=0, then round robin across all three masters.
    tenure(3'b101, 3'b001, 2'd0);
    tenure(3'b111, 3'b010, 2'd1);
    tenure(3'b111, 3'b100, 2'd2);
    tenure(3'b111, 3'b001, 2'd0);

    // slave_busy keeps the tenure alive after bus_util falls.
    s(3'b010, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, "sb_grant");
    s(3'b010, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, "sb_busy");
    repeat (5) s(3'b010, 1'b0, 1'b1, 3'b010, 2'd1, 1'b1, 1'b0, "sb_extend");
    s(3'b010, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "sb_release");
    s(3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "sb_idle");

    // Hold timeout with bus_util stuck high.
    s(3'b100, 1'b0, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0, "hto_grant");
    s(3'b100, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0, "hto_enter");
    repeat (63) s(3'b100, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1, 1'b0, "hto_hold");
    s(3'b100, 1'b1, 1'b0, 3'b100, 2'd2, 1'b1, 1'b1, "hto_pulse");
    s(3'b100, 1'b1, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "hto_release");
    s(3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "hto_idle");

    // bus_util arrives on the cycle the wait counter hits its limit.
    s(3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0, "tie_grant");
    repeat (3) s(3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0, "tie_wait");
    s(3'b001, 1'b1, 1'b0, 3'b001, 2'd0, 1'b1, 1'b0, "tie_util");
    s(3'b001, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "tie_release");
    s(3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "tie_idle");

    // Normal end on the cycle the hold counter hits its limit.
    s(3'b010, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, "tie2_grant");
    s(3'b010, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, "tie2_enter");
    repeat (63) s(3'b010, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, 1'b0, "tie2_hold");
    s(3'b010, 1'b0, 1'b0, 3'b000, 2'd0, 1'b1, 1'b0, "tie2_release");
    s(3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, "tie2_idle");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 3, meaning number of requesting masters (2..4).
REQ-002 Parameter GRANT_WAIT, default 4, meaning max cycles a granted master may take to raise bus_util.
REQ-003 Parameter MAX_HOLD, default 64, meaning max cycles one tenure may occupy the bus (bus_util or slave_busy high).
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_MASTERS  per-master bus request; level, held until tenure ends.
REQ-007 bus_util  input  1  high while the granted master is driving data_bus_serial.
REQ-008 slave_busy  input  1  wired-OR slave busy line; Z/0 resolves to 0.
REQ-009 grant  output  NUM_MASTERS  one-hot bus grant; all-zero when bus free.
REQ-010 grant_id  output  2  binary index of granted master; valid only when grant nonzero.
REQ-011 arb_busy  output  1  high whenever state is not IDLE.
REQ-012 timeout  output  1  single-cycle pulse when a tenure is revoked.

Function
REQ-013 FSM states: IDLE, GRANT, BUSY, RELEASE; all outputs registered.
REQ-014 IDLE: if req nonzero, select first requester at or after pointer ptr (circular search), assert its grant bit next edge, go to GRANT; else stay.
REQ-015 Latency: req sampled high in IDLE -> grant high on the following edge (1 cycle).
REQ-016 GRANT: wait counter counts from 0 each cycle; bus_util=1 -> BUSY, counter cleared.
REQ-017 GRANT: granted master drops req before bus_util -> RELEASE, no timeout.
REQ-018 GRANT: counter reaches GRANT_WAIT without bus_util -> timeout pulse, RELEASE.
REQ-019 BUSY: hold counter increments each cycle; bus_util=0 and slave_busy=0 -> RELEASE.
REQ-020 BUSY: slave_busy=1 keeps tenure alive after bus_util falls (read turnaround).
REQ-021 BUSY: hold counter reaches MAX_HOLD -> timeout pulse, RELEASE, regardless of bus_util/slave_busy.
REQ-022 RELEASE: grant all-zero, lasts exactly 1 cycle, ptr := (granted index + 1) mod NUM_MASTERS, then IDLE.
REQ-023 Minimum gap between two grants: 2 cycles of all-zero grant (RELEASE + IDLE).
REQ-024 grant never has more than one bit set; grant and grant_id change only on IDLE->GRANT and on entering RELEASE.
REQ-025 Requests from non-granted masters during a tenure are ignored until IDLE; no queuing beyond req levels.
REQ-026 req bits at index >= NUM_MASTERS are not present; ptr wraps from NUM_MASTERS-1 to 0.
REQ-027 Counters saturate at their limit; width = clog2(limit)+1.
REQ-028 Simultaneous timeout and normal end in same cycle: normal end wins, no timeout pulse.

Reset
REQ-029 rst=1 at a clock edge: state IDLE, ptr 0, counters 0, grant 0, grant_id 0, arb_busy 0, timeout 0.
REQ-030 rst mid-tenure drops grant on the same edge; first post-reset grant follows REQ-015 with ptr 0.

Verification
REQ-031 Single request: req=3'b010 in IDLE -> grant=3'b010, grant_id=1 one cycle later; bus_util high 3 cycles then low -> RELEASE, grant=0, ptr=2.
REQ-032 Round robin: req=3'b111 held, each master raises bus_util 2 cycles -> grant sequence 001,010,100,001 with 2-cycle zero gaps.
REQ-033 Grant timeout: req=3'b001, bus_util never rises -> timeout pulse exactly 4 cycles after grant, grant=0 next cycle, ptr=1.
REQ-034 Hold timeout: bus_util stuck high -> timeout pulse at hold count 64, grant revoked next cycle.
REQ-035 Slave busy extension: bus_util falls while slave_busy=1 for 5 cycles -> grant held until slave_busy low, then RELEASE.
REQ-036 Reset mid-BUSY: rst=1 one cycle with grant=3'b100 -> all outputs 0 next edge; req=3'b101 afterwards -> grant=3'b001.
